// File: rtl/map_generate_pkg.sv
// map_generate_pkg: board geometry, screen codes, cell codes and FSM states shared by the board generator.
package map_generate_pkg;
    localparam int MAP_HEIGHT      = 8;
    localparam int MAP_WIDTH       = 8;
    localparam int MAP_CELL_LENGTH = 4;
    localparam int MINE_NUM        = 10;
    localparam int CELLS           = MAP_HEIGHT * MAP_WIDTH;
    localparam int IDX_W           = $clog2(CELLS);
    localparam int CNT_W           = $clog2(MINE_NUM + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [2:0] SCREEN_BOOT = 3'd0;
    localparam logic [2:0] SCREEN_MENU = 3'd1;
    localparam logic [2:0] SCREEN_GAME = 3'd2;
    localparam logic [2:0] SCREEN_WIN  = 3'd3;
    localparam logic [2:0] SCREEN_LOSE = 3'd4;
    localparam logic [MAP_CELL_LENGTH-1:0] CELL_MINE = 4'd9;
    typedef enum logic [1:0] {IDLE, PLACE, COUNT, DONE} state_t;
endpackage

// File: rtl/map_generate_if.sv
// map_generate_if: screen code in, flattened board and mine bitmap out.
interface map_generate_if;
    import map_generate_pkg::*;
    logic [2:0]                       screen_state_i;
    logic [MAP_CELL_LENGTH*CELLS-1:0] map_o;
    logic [CELLS-1:0]                 map_mine_o;
    modport master (input screen_state_i, output map_o, map_mine_o);
    modport slave  (output screen_state_i, input map_o, map_mine_o);
endinterface

// File: rtl/map_generate_lfsr.sv
// map_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11) with synchronous seed reload.
module map_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= SEED;
        else        q <= load ? SEED : ({1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000));
endmodule

// File: rtl/map_generate.sv
// map_generate: Minesweeper board generator placing MINE_NUM random mines, then neighbour counts.
// Define MAP_FIXED_SEED_EN to reload the LFSR seed on every trigger for reproducible boards.
module map_generate
    import map_generate_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    map_generate_if.master bus
);
    logic [15:0]                      lfsr;
    logic [2:0]                       prev_state;
    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt;
    logic [CELLS-1:0]                 mine_q;
    logic [MAP_CELL_LENGTH*CELLS-1:0] map_q, count_map;
    logic [IDX_W-1:0]                 idx;
    logic trigger, hit, keep_board, reload, clear, place, load_map;
    logic [MAP_HEIGHT+1:0][MAP_WIDTH+1:0] pad;

    assign idx        = lfsr[IDX_W-1:0];
    assign trigger    = bus.screen_state_i == SCREEN_GAME && prev_state != SCREEN_GAME;
    assign hit        = {1'b0, idx} < (IDX_W+1)'(CELLS) && !mine_q[idx];
    assign keep_board = bus.screen_state_i == SCREEN_GAME || bus.screen_state_i == SCREEN_WIN ||
                        bus.screen_state_i == SCREEN_LOSE;
    assign bus.map_o      = map_q;
    assign bus.map_mine_o = mine_q;
`ifdef MAP_FIXED_SEED_EN
    assign reload = trigger;
`else
    assign reload = 1'b0;
`endif

    map_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .load(reload), .q(lfsr));

    // Zero border around the grid so edge cells need no special casing.
    always_comb begin
        pad = '0;
        for (int r = 0; r < MAP_HEIGHT; r++)
            for (int c = 0; c < MAP_WIDTH; c++)
                pad[r+1][c+1] = mine_q[r*MAP_WIDTH+c];
    end

    for (genvar r = 0; r < MAP_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < MAP_WIDTH; c++) begin : g_col
            logic [MAP_CELL_LENGTH-1:0] n;
            assign n = MAP_CELL_LENGTH'(pad[r][c])   + MAP_CELL_LENGTH'(pad[r][c+1])   +
                       MAP_CELL_LENGTH'(pad[r][c+2]) + MAP_CELL_LENGTH'(pad[r+1][c])   +
                       MAP_CELL_LENGTH'(pad[r+1][c+2]) + MAP_CELL_LENGTH'(pad[r+2][c]) +
                       MAP_CELL_LENGTH'(pad[r+2][c+1]) + MAP_CELL_LENGTH'(pad[r+2][c+2]);
            assign count_map[(r*MAP_WIDTH+c)*MAP_CELL_LENGTH +: MAP_CELL_LENGTH] =
                mine_q[r*MAP_WIDTH+c] ? CELL_MINE : n;
        end
    end

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        place    = 1'b0;
        load_map = 1'b0;
        case (state_q)
            IDLE:  if (trigger) begin clear = 1'b1; state_d = PLACE; end
            PLACE: if (bus.screen_state_i != SCREEN_GAME) begin
                       clear   = 1'b1;
                       state_d = IDLE;
                   end else if (hit) begin
                       place   = 1'b1;
                       state_d = cnt == CNT_W'(MINE_NUM - 1) ? COUNT : PLACE;
                   end
            COUNT: begin load_map = 1'b1; state_d = DONE; end
            DONE:  if (trigger) begin
                       clear   = 1'b1;
                       state_d = PLACE;
                   end else if (!keep_board) begin
                       clear   = 1'b1;
                       state_d = IDLE;
                   end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_state <= SCREEN_BOOT;
            cnt        <= '0;
            mine_q     <= '0;
            map_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_state <= bus.screen_state_i;
            if (clear) begin
                cnt    <= '0;
                mine_q <= '0;
                map_q  <= '0;
            end else begin
                if (place) begin
                    mine_q[idx] <= 1'b1;
                    cnt         <= cnt + 1'b1;
                end
                if (load_map) map_q <= count_map;
            end
        end
endmodule

// File: tb/tb_map_generate.sv
// tb_map_generate: directed checks of board generation, screen transitions, abort and async reset.
module tb_map_generate;
    import map_generate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] m_lfsr;
    logic [63:0] m1, m2, m3, m4;
    logic [15:0] s;

    map_generate_if bus ();
    map_generate dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= LFSR_SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);

    function automatic logic [255:0] board(input logic [63:0] m);
        logic [255:0] b;
        int n;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                            n += int'(m[(r + dr) * 8 + c + dc]);
                b[(r * 8 + c) * 4 +: 4] = m[r * 8 + c] ? 4'd9 : 4'(n);
            end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] start_value();
`ifdef MAP_FIXED_SEED_EN
        return LFSR_SEED;
`else
        return m_lfsr;
`endif
    endfunction

    task automatic game(input string tag, output logic [63:0] exp_m);
        logic [15:0] v;
        logic [63:0] m;
        int placed, k;
        bus.screen_state_i = SCREEN_GAME;
        @(negedge clk);
        v = start_value();
        m = '0;
        placed = 0;
        k = 0;
        while (placed < MINE_NUM && k < 64 * MINE_NUM) begin
            if (!m[v[5:0]]) begin
                m[v[5:0]] = 1'b1;
                placed++;
            end
            v = lfsr_next(v);
            k++;
        end
        repeat (k) @(negedge clk);
        chk({tag, " map during COUNT"}, bus.map_o, '0);
        chk({tag, " mines placed"}, 256'(bus.map_mine_o), 256'(m));
        @(negedge clk);
        chk({tag, " board"}, bus.map_o, board(m));
        chk({tag, " popcount"}, 256'($countones(bus.map_mine_o)), 256'(MINE_NUM));
        repeat (100) @(negedge clk);
        chk({tag, " board stable"}, bus.map_o, board(m));
        chk({tag, " mines stable"}, 256'(bus.map_mine_o), 256'(m));
        exp_m = m;
    endtask

    initial begin
        bus.screen_state_i = SCREEN_BOOT;
        repeat (2) @(negedge clk);
        chk("reset map", bus.map_o, '0);
        chk("reset mines", 256'(bus.map_mine_o), '0);
        rst_n = 1'b1;
        bus.screen_state_i = SCREEN_MENU;
        repeat (5) @(negedge clk);
        game("g1", m1);

        bus.screen_state_i = SCREEN_LOSE;
        repeat (3) @(negedge clk);
        chk("lose keeps board", bus.map_o, board(m1));
        chk("lose keeps mines", 256'(bus.map_mine_o), 256'(m1));
        bus.screen_state_i = SCREEN_MENU;
        @(negedge clk);
        chk("menu clears map", bus.map_o, '0);
        chk("menu clears mines", 256'(bus.map_mine_o), '0);
        repeat (5) @(negedge clk);
        game("g2", m2);
`ifdef MAP_FIXED_SEED_EN
        chk("fixed seed boards equal", 256'(m1 == m2 && bus.map_mine_o == m1), 256'(1));
`else
        chk("dwell 5 vs 6 boards differ", 256'(m1 != m2 && bus.map_mine_o != m1), 256'(1));
`endif

        bus.screen_state_i = SCREEN_WIN;
        repeat (2) @(negedge clk);
        game("g3", m3);

        bus.screen_state_i = SCREEN_MENU;
        repeat (3) @(negedge clk);
        bus.screen_state_i = SCREEN_GAME;
        @(negedge clk);
        s = start_value();
        @(negedge clk);
        chk("abort first mine", 256'(bus.map_mine_o), 256'(64'(1) << s[5:0]));
        bus.screen_state_i = SCREEN_MENU;
        @(negedge clk);
        chk("abort clears map", bus.map_o, '0);
        chk("abort clears mines", 256'(bus.map_mine_o), '0);
        repeat (3) @(negedge clk);
        chk("abort stays idle", 256'(bus.map_mine_o), '0);

        bus.screen_state_i = SCREEN_GAME;
        repeat (3) @(negedge clk);
        chk("mid-place mines nonzero", 256'(|bus.map_mine_o), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset map", bus.map_o, '0);
        chk("async reset mines", 256'(bus.map_mine_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.screen_state_i = SCREEN_MENU;
        repeat (4) @(negedge clk);
        game("g4", m4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
